seq_comparator_8: RTL
=====================

SEQ_COMPARATOR_8 -- requirements
Module: seq_comparator_8

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits, processed as four 2-bit pairs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair x/y presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 x  input  8  first operand, unsigned.
REQ-007 y  input  8  second operand, unsigned.
REQ-008 out_valid  output  1  result g/l valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 g  output  1  result: x > y.
REQ-011 l  output  1  result: x < y; g=l=0 means x == y.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, x/y are latched, the pair index is set to 3 and the next state is RUN.
REQ-014 RUN: in_ready=0, out_valid=0; one pair per cycle, MSB first ({x[7:6]},{x[5:4]},{x[3:2]},{x[1:0]} against the matching y pair).
REQ-015 Decision rule: the first pair that differs fixes g/l; later pairs are ignored once g or l is set; g and l are never both 1.
REQ-016 RUN SHALL exit to DONE after the pair-0 cycle, giving a fixed latency: accept edge T, out_valid high after edge T+4.
REQ-017 DONE: out_valid=1, g/l stable, in_ready=0; on out_ready the next state is IDLE and out_valid drops after that edge.
REQ-018 out_ready held high continuously SHALL give a throughput of one result per 6 cycles (accept, 4 x RUN, DONE); in_ready is not asserted in DONE.
REQ-019 in_valid asserted outside IDLE SHALL be ignored; x/y changes after acceptance SHALL NOT affect the result.
REQ-020 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-021 rst high SHALL immediately force the state to IDLE, with in_ready=1, out_valid=0, g=0, l=0, latched operands=0 and pair index=0.
REQ-022 Reset in RUN or DONE SHALL abort the operation with no result delivered; the first edge after rst deasserts SHALL be able to accept new operands.

Configuration
REQ-023 The macro SEQ_CMP_EARLY_EXIT_EN SHALL control early exit.
- Defined: RUN goes to DONE on the first cycle a pair differs, so latency is 1-4 cycles. Equal operands still take 4 cycles.
- Undefined: latency is always 4 cycles, per REQ-016.
- g/l values are identical in both builds.

Structure
REQ-024 A shared package seq_cmp_pkg SHALL hold:
- the FSM state typedef (IDLE/RUN/DONE);
- the constants PAIR_W=2 and NUM_PAIRS=4.
REQ-025 Per-pair compare SHALL reuse the existing 2-bit comparator_primitives module as the single sub-module (ports a[1:0], b[1:0], g, l), fed by a mux on the pair index.
REQ-026 Total RTL SHALL be 120-400 lines, with no combinational path from in_valid to out_valid.

Verification
REQ-027 x=8'hA5, y=8'h5A accepted at edge T, out_ready=1 -> g=1, l=0; out_valid high after edge T+4 (no macro) or after T+1 (macro).
REQ-028 x=8'h3C, y=8'h3D -> g=0, l=1; out_valid after T+4 in both builds.
REQ-029 x=y=8'h77 -> g=0, l=0 after T+4; then x=8'h00, y=8'hFF -> l=1 (back-to-back, out_ready tied high, 6-cycle spacing).
REQ-030 out_ready=0 for 10 cycles in DONE -> out_valid and g/l held, in_ready=0, and a new in_valid is ignored; a 1-cycle out_ready pulse -> back to IDLE.
REQ-031 rst pulse 2 cycles after accepting x=8'hFF, y=8'h00 -> out_valid never asserts, outputs are at reset values, and the next transaction x=8'h01, y=8'h02 gives l=1.
REQ-032 Randomised 1000 operand pairs checked against the reference result x>y / x<y, with random out_ready stalls; both macro builds run.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the sequential 8-bit comparator.
// Pair geometry and the three-state FSM encoding live here.
package seq_cmp_pkg;

  localparam int PAIR_W    = 2;
  localparam int NUM_PAIRS = 4;
  localparam int OP_W      = PAIR_W * NUM_PAIRS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [PAIR_W-1:0] pair_sel(
    input logic [OP_W-1:0] v,
    input logic [1:0]      i
  );
    return v[{i, 1'b0} +: PAIR_W];
  endfunction

endpackage

// File: rtl/comparator_primitives.sv
// 2-bit unsigned magnitude comparator.
// g = a > b, l = a < b; both low when equal.
module comparator_primitives (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       g,
  output logic       l
);

  assign g = a > b;
  assign l = a < b;

endmodule

// File: rtl/seq_comparator_8.sv
// Sequential 8-bit comparator, MSB pair first, valid/ready on both sides.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing pair.
module seq_comparator_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       g,
  output logic       l
);
  import seq_cmp_pkg::*;

  state_e          state_q, state_d;
  logic [OP_W-1:0] x_q, x_d;
  logic [OP_W-1:0] y_q, y_d;
  logic [1:0]      idx_q, idx_d;
  logic            g_q, g_d;
  logic            l_q, l_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [PAIR_W-1:0] pa, pb;
  logic              pg, pl;
  logic              last;

  assign pa = pair_sel(x_q, idx_q);
  assign pb = pair_sel(y_q, idx_q);

  comparator_primitives u_cmp (
    .a (pa),
    .b (pb),
    .g (pg),
    .l (pl)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
    g_d         = g_q;
    l_d         = l_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    last        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = x;
          y_d        = y;
          idx_d      = 2'd3;
          g_d        = 1'b0;
          l_d        = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Only the first differing pair may decide the result.
        if (!g_q && !l_q) begin
          g_d = pg;
          l_d = pl;
        end
`ifdef SEQ_CMP_EARLY_EXIT_EN
        last = (idx_q == 2'd0) || pg || pl;
`else
        last = (idx_q == 2'd0);
`endif
        if (last) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      g_q         <= 1'b0;
      l_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      g_q         <= g_d;
      l_q         <= l_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign g         = g_q;
  assign l         = l_q;

endmodule
